mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_en, i_read  input  1  instruction-port request and direction (1=read).
REQ-006 SHALL have ports i_addr  input  ADDR_W and i_wdata  input  DATA_W  instruction-port address and write data.
REQ-007 SHALL have ports i_ack  output  1 and i_rdata  output  DATA_W  instruction-port completion pulse and read data.
REQ-008 SHALL have ports d_en, d_read, d_addr, d_wdata, d_ack, d_rdata with the same directions, widths and meanings for the data port.
REQ-009 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  downstream request.
REQ-010 SHALL have ports mem_rdata  input  DATA_W and mem_ack  input  1  downstream response; mem_ack is a one-cycle pulse.

Function
REQ-011 SHALL implement states IDLE, BUSY, DONE.
REQ-012 In IDLE, no request: SHALL stay in IDLE with mem_req=0.
REQ-013 In IDLE, exactly one of i_en/d_en high: SHALL grant that port and go to BUSY.
REQ-014 In IDLE, both high: SHALL grant the port not granted last (round-robin pointer); the pointer SHALL favour the data port after reset.
REQ-015 On grant: SHALL register addr, wdata and mem_we=!read from the granted port, and assert mem_req from the next cycle; later changes on requester inputs SHALL NOT affect the transaction.
REQ-016 In BUSY: SHALL hold mem_req and all mem_* outputs stable until mem_ack is sampled high.
REQ-017 On mem_ack in BUSY: SHALL deassert mem_req, register mem_rdata into the granted port's rdata, pulse that port's ack for exactly one cycle, go to DONE, and update the pointer to the granted port.
REQ-018 Writes SHALL be acknowledged identically to reads; rdata on a write ack is don't-care but SHALL be the registered mem_rdata.
REQ-019 In DONE: SHALL grant nothing and return to IDLE; the requester uses the ack cycle to drop or change en.
REQ-020 Minimum latency, en high to ack high, SHALL be 3 cycles with zero-wait memory (grant edge, mem_ack edge, ack cycle); requests SHALL NOT overlap.
REQ-021 mem_ack in IDLE or DONE SHALL be ignored.
REQ-022 A requester deasserting en during BUSY SHALL NOT abort the transaction; its ack still pulses.
REQ-023 i_ack and d_ack SHALL never be high in the same cycle.
REQ-024 rdata outputs SHALL hold their last value between acks.

Reset
REQ-025 While rst is high: state IDLE, pointer=data-favoured, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ack=d_ack=0, i_rdata=d_rdata=0.
REQ-026 Reset asserted during BUSY SHALL drop mem_req immediately; the in-flight transaction is lost and no ack is issued for it.

Structure
REQ-027 The shared package SHALL hold the state encoding (IDLE/BUSY/DONE) and port-id constants (PORT_I, PORT_D).
REQ-028 Round-robin selection SHALL be a sub-module arb_rr_pick: inputs two requests and last-grant id; output grant-valid and grant id; purely combinational.

Verification
REQ-029 d_en=1, d_read=1, d_addr=0x100, mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, d_ack one cycle, d_rdata=0xDEADBEEF, i_ack stays 0.
REQ-030 i_en and d_en both high from reset, zero-wait memory -> grants D, I, D, I alternating; no ack collision.
REQ-031 i_en=1 write, i_addr=0x40, i_wdata=0x12345678, change i_addr to 0x80 during BUSY -> mem_addr stays 0x40, mem_we=1, i_ack pulses once.
REQ-032 mem_ack delayed 5 cycles -> mem_req high 5 cycles with stable outputs; ack exactly one cycle after the mem_ack sample.
REQ-033 rst pulse mid-BUSY -> mem_req=0 asynchronously, no ack, next d_en request served normally.
REQ-034 Spurious mem_ack in IDLE -> no ack, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding and port ids.
package mem_arbiter_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Requester identifiers, also used as the round-robin pointer value
  typedef logic port_id_t;
  localparam port_id_t PORT_I = 1'b0;
  localparam port_id_t PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module arb_rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic     ireq_i,
  input  logic     dreq_i,
  input  port_id_t last_gnt_i,
  output logic     gnt_vld_o,
  output port_id_t gnt_id_o
);

  // Pure combinational selection; a lone requester always wins.
  always_comb begin
    gnt_vld_o = ireq_i | dreq_i;
    gnt_id_o  = PORT_I;
    if (ireq_i && dreq_i) begin
      gnt_id_o = (last_gnt_i == PORT_I) ? PORT_D : PORT_I;
    end else if (dreq_i) begin
      gnt_id_o = PORT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one memory request
// channel. One transaction at a time: IDLE -> BUSY -> DONE -> IDLE.
//
//   state | meaning
//   IDLE  | waiting for a request; grants on the next edge
//   BUSY  | mem_req held with registered address/data until mem_ack
//   DONE  | ack cycle; requester may drop or change its request
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_en,
  input  logic              d_read,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  logic [1:0]        state_q, state_d;
  port_id_t          last_q, last_d;
  port_id_t          gnt_q, gnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic     pick_vld;
  port_id_t pick_id;

  arb_rr_pick u_pick (
    .ireq_i     (i_en),
    .dreq_i     (d_en),
    .last_gnt_i (last_q),
    .gnt_vld_o  (pick_vld),
    .gnt_id_o   (pick_id)
  );

  // Next-state logic: grant in IDLE, wait for mem_ack in BUSY, one idle ack cycle in DONE.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d   = ST_BUSY;
          gnt_d     = pick_id;
          mem_req_d = 1'b1;
          if (pick_id == PORT_D) begin
            mem_we_d    = ~d_read;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = ~i_read;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_wdata;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          last_d    = gnt_q;
          if (gnt_q == PORT_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_rdata;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State registers; reset leaves the pointer favouring the data port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT_I;
      gnt_q       <= PORT_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a driver pushes expected transactions per
// port, a memory model answers after a programmable wait, and a monitor pops
// and compares on every ack.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en, i_read, d_en, d_read;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_ack, d_ack;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_chk  = 0;
  int n_fail = 0;

  int mem_wait  = 0;
  int spur_cnt  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wt;
  } exp_t;

  exp_t q_i[$];
  exp_t q_d[$];
  bit   log_port[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_en      (d_en),
    .d_read    (d_read),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: answers mem_wait cycles after mem_req rises; can inject a stray ack.
  initial begin
    int cnt;
    int spur_done;
    cnt = 0;
    spur_done = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !mem_req) begin
        cnt = 0;
        mem_ack = 1'b0;
        if (!rst && spur_cnt != spur_done) begin
          mem_ack = 1'b1;
          mem_rdata = 32'hBAD0BAD0;
          spur_done++;
        end
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (cnt == mem_wait) begin
        mem_ack = 1'b1;
        mem_rdata = mem_fn(mem_addr);
      end else begin
        cnt++;
      end
    end
  end

  // Monitor: hold checks while mem_req is high, scoreboard compare on each ack.
  logic        prev_req;
  int          rlen;
  logic [31:0] cap_addr, cap_wdata, last_i, last_d;
  logic        cap_we;
  initial begin
    exp_t e;
    prev_req = 1'b0;
    rlen = 0;
    cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    last_i = '0; last_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
        rlen = 0;
        last_i = '0;
        last_d = '0;
      end else begin
        if (mem_req) begin
          if (!prev_req) begin
            cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
            rlen = 1;
          end else begin
            rlen++;
            chk("hold_addr", mem_addr, cap_addr);
            chk("hold_we", mem_we, cap_we);
            chk("hold_wdata", mem_wdata, cap_wdata);
          end
        end
        if (i_ack || d_ack) begin
          chk("ack_collision", i_ack & d_ack, 0);
          chk("ack_after_req", prev_req, 1);
          chk("req_drop_on_ack", mem_req, 0);
        end
        if (d_ack) begin
          if (q_d.size() == 0) chk("unexpected_d_ack", d_ack, 0);
          else begin
            e = q_d.pop_front();
            chk("d_addr", cap_addr, e.addr);
            chk("d_we", cap_we, e.we);
            if (e.we) chk("d_wdata", cap_wdata, e.wdata);
            chk("d_rdata", d_rdata, e.rdata);
            chk("d_req_len", rlen, e.wt + 1);
            chk("i_rdata_hold", i_rdata, last_i);
            last_d = e.rdata;
            log_port.push_back(1'b1);
          end
        end
        if (i_ack) begin
          if (q_i.size() == 0) chk("unexpected_i_ack", i_ack, 0);
          else begin
            e = q_i.pop_front();
            chk("i_addr", cap_addr, e.addr);
            chk("i_we", cap_we, e.we);
            if (e.we) chk("i_wdata", cap_wdata, e.wdata);
            chk("i_rdata", i_rdata, e.rdata);
            chk("i_req_len", rlen, e.wt + 1);
            chk("d_rdata_hold", d_rdata, last_d);
            last_i = e.rdata;
            log_port.push_back(1'b0);
          end
        end
        prev_req = mem_req;
      end
    end
  end

  // One request from IDLE; optionally mutates the requester inputs during BUSY.
  task automatic do_req(input bit port, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input int wt, input bit mut);
    exp_t e;
    int   lat;
    bit   got;
    e.we = ~rd; e.addr = addr; e.wdata = wdata; e.rdata = mem_fn(addr); e.wt = wt;
    mem_wait = wt;
    if (port) begin
      q_d.push_back(e);
      d_en = 1'b1; d_read = rd; d_addr = addr; d_wdata = wdata;
    end else begin
      q_i.push_back(e);
      i_en = 1'b1; i_read = rd; i_addr = addr; i_wdata = wdata;
    end
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (mut && k == 0) begin
        if (port) begin d_addr = addr ^ 32'hC0; d_wdata = ~wdata; d_read = ~rd; end
        else      begin i_addr = addr ^ 32'hC0; i_wdata = ~wdata; i_read = ~rd; end
      end
      if (port ? d_ack : i_ack) got = 1'b1;
    end
    chk("ack_seen", got, 1);
    if (got) chk("latency", lat, 3 + wt);
    if (port) d_en = 1'b0; else i_en = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", port ? d_ack : i_ack, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   acks;
    rst = 1'b1;
    i_en = 1'b1; i_read = 1'b1; i_addr = 32'h200; i_wdata = 32'h1111;
    d_en = 1'b1; d_read = 1'b1; d_addr = 32'h300; d_wdata = 32'h2222;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // Both ports requesting from reset: D, I, D, I, D, I.
    for (int k = 0; k < 3; k++) begin
      e.we = 1'b0; e.wt = 0;
      e.addr = 32'h300; e.wdata = 32'h2222; e.rdata = mem_fn(32'h300); q_d.push_back(e);
      e.addr = 32'h200; e.wdata = 32'h1111; e.rdata = mem_fn(32'h200); q_i.push_back(e);
    end
    mem_wait = 0;
    rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 60 && acks < 6; k++) begin
      @(negedge clk);
      if (i_ack) acks++;
      if (d_ack) acks++;
    end
    chk("rr_acks", acks, 6);
    i_en = 1'b0; d_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rr_count", log_port.size(), 6);
    for (int k = 0; k < 6 && k < log_port.size(); k++)
      chk($sformatf("rr_order_%0d", k), log_port[k], (k % 2 == 0) ? 1 : 0);
    log_port.delete();

    do_req(1'b1, 1'b1, 32'h100, 32'h0, 0, 1'b0);
    chk("d_rdata_deadbeef", d_rdata, 32'hDEADBEEF);
    do_req(1'b0, 1'b0, 32'h40, 32'h12345678, 0, 1'b1);
    do_req(1'b1, 1'b1, 32'h500, 32'h0, 4, 1'b0);
    do_req(1'b1, 1'b0, 32'h600, 32'hCAFEF00D, 2, 1'b0);

    // Stray mem_ack while idle.
    spur_cnt++;
    repeat (4) @(negedge clk);
    chk("spur_mem_req", mem_req, 0);
    chk("spur_i_ack", i_ack, 0);
    chk("spur_d_ack", d_ack, 0);
    do_req(1'b0, 1'b1, 32'h700, 32'h0, 0, 1'b0);

    // Reset in the middle of a long transaction.
    mem_wait = 20;
    d_en = 1'b1; d_read = 1'b1; d_addr = 32'h900; d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_d_rdata", d_rdata, 0);
    d_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_d_ack", d_ack, 0);
    chk("post_rst_mem_req", mem_req, 0);
    do_req(1'b1, 1'b1, 32'hA00, 32'h0, 0, 1'b0);

    repeat (2) @(negedge clk);
    chk("queues_empty", q_i.size() + q_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
